// File: rtl/reception.sv
// UART 8N1 receiver that reassembles BUFFER_SIZE/8 consecutive bytes (low byte first) into one word.
// Optional feature macro: RECEIVER_TIMEOUT_EN (drops a stale partial word after 20 bit times idle).
module reception #(
    parameter int BUFFER_SIZE = 16,
    parameter int CLOCK       = 65000000,
    parameter int BAUD        = 9600
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rx_in,
    output logic [BUFFER_SIZE-1:0] data_out,
    output logic                   valid_out,
    output logic                   frame_error_out
);

    localparam int DIVISOR = CLOCK / BAUD;
    localparam int HALF    = DIVISOR / 2;
    localparam int BYTES   = BUFFER_SIZE / 8;
    localparam int BC_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int PTR_W   = $clog2(BYTES) + 1;

    localparam logic [BC_W-1:0]  HALF_END = BC_W'(HALF - 1);
    localparam logic [BC_W-1:0]  DIV_END  = BC_W'(DIVISOR - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state, state_d;
    logic                   rx_meta, rx_s, rx_q;
    logic                   start_edge;
    logic [BC_W-1:0]        baud_count, baud_d;
    logic [2:0]             bit_count, bit_d;
    logic [PTR_W-1:0]       byte_ptr, ptr_d;
    logic [7:0]             shift, shift_d;
    logic [BUFFER_SIZE-1:0] word, word_d;
    logic [BUFFER_SIZE-1:0] data_d;
    logic                   valid_d, ferr_d;

`ifdef RECEIVER_TIMEOUT_EN
    localparam int TMO_CYCLES = 20 * DIVISOR;
    localparam int TMO_W      = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_END = TMO_W'(TMO_CYCLES - 1);

    logic [TMO_W-1:0] idle_cnt, idle_cnt_d;
`endif

    assign start_edge = rx_q & ~rx_s;

    // Synchroniser and edge-detect register; idle-high reset avoids a false start edge
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            baud_count      <= '0;
            bit_count       <= '0;
            byte_ptr        <= '0;
            data_out        <= '0;
            valid_out       <= 1'b0;
            frame_error_out <= 1'b0;
        end else begin
            state           <= state_d;
            baud_count      <= baud_d;
            bit_count       <= bit_d;
            byte_ptr        <= ptr_d;
            data_out        <= data_d;
            valid_out       <= valid_d;
            frame_error_out <= ferr_d;
        end
    end

`ifdef RECEIVER_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt_d;
        end
    end
`endif

    // Assembly registers carry no control meaning, so they are left out of reset
    always_ff @(posedge clk_in) begin
        shift <= shift_d;
        word  <= word_d;
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_count;
        bit_d   = bit_count;
        ptr_d   = byte_ptr;
        shift_d = shift;
        word_d  = word;
        data_d  = data_out;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                    baud_d  = '0;
                end
            end

            START: begin
                if (baud_count == HALF_END) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        baud_d  = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_count + 1'b1;
                end
            end

            DATA: begin
                if (baud_count == DIV_END) begin
                    baud_d             = '0;
                    shift_d[bit_count] = rx_s;
                    bit_d              = bit_count + 3'd1;
                    if (bit_count == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_count + 1'b1;
                end
            end

            STOP: begin
                if (baud_count == DIV_END) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        for (int k = 0; k < BYTES; k++) begin
                            if (byte_ptr == PTR_W'(k)) begin
                                word_d[8*k +: 8] = shift;
                            end
                        end
                        if (byte_ptr == PTR_LAST) begin
                            data_d  = word_d;
                            valid_d = 1'b1;
                            ptr_d   = '0;
                        end else begin
                            ptr_d = byte_ptr + 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                        ptr_d  = '0;
                    end
                end else begin
                    baud_d = baud_count + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef RECEIVER_TIMEOUT_EN
        idle_cnt_d = idle_cnt;
        if (state == IDLE && start_edge) begin
            idle_cnt_d = '0;
        end else if (state == IDLE && byte_ptr != '0) begin
            if (idle_cnt == TMO_END) begin
                idle_cnt_d = '0;
                ptr_d      = '0;
            end else begin
                idle_cnt_d = idle_cnt + 1'b1;
            end
        end else if (byte_ptr == '0) begin
            idle_cnt_d = '0;
        end
`endif
    end

endmodule

// File: tb/tb_reception.sv
// Directed bench for reception: 16-bit words at DIVISOR = 1000/100 = 10 clocks per bit.
module tb_reception;

    localparam int DIV = 10;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rx_in;
    logic [15:0] data_out;
    logic        valid_out;
    logic        frame_error_out;

    reception #(
        .BUFFER_SIZE(16),
        .CLOCK      (1000),
        .BAUD       (100)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rx_in          (rx_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .frame_error_out(frame_error_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc      = 0;
    int          vcyc     = 0;
    int          vrise    = 0;
    int          fcyc     = 0;
    int          overlap  = 0;
    int          stab_err = 0;
    int          vstamp[2];
    logic [15:0] vdata[2];
    logic        prev_valid = 1'b0;
    logic [15:0] prev_data  = 16'h0;
    bit          skip_stab  = 1'b1;

    // Output recorder, sampled away from the active edge
    always @(negedge clk_in) begin
        cyc++;
        if (valid_out === 1'b1) begin
            vcyc++;
            if (prev_valid !== 1'b1) vrise++;
            vstamp[0] = vstamp[1];
            vstamp[1] = cyc;
            vdata[0]  = vdata[1];
            vdata[1]  = data_out;
        end
        if (frame_error_out === 1'b1) fcyc++;
        if (valid_out === 1'b1 && frame_error_out === 1'b1) overlap++;
        if (!skip_stab && valid_out !== 1'b1 && data_out !== prev_data) stab_err++;
        prev_valid = valid_out;
        prev_data  = data_out;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_in = f[i];
            repeat (DIV) @(negedge clk_in);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        rx_in  = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if (data_out !== 16'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected %h", data_out, 16'h0);
        end
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out);
        end
        n_checks++;
        if (frame_error_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_error_out);
        end
        rst_in = 1'b0;
        idle(5);
        skip_stab = 1'b0;
    endtask

    task automatic test_basic();
        int v0, r0, f0;
        v0 = vcyc; r0 = vrise; f0 = fcyc;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        idle(10);
        n_checks++;
        if (data_out !== 16'h3CA5) begin
            n_fail++; $display("FAIL basic_data: got %h expected %h", data_out, 16'h3CA5);
        end
        n_checks++;
        if (vcyc - v0 !== 1) begin
            n_fail++; $display("FAIL basic_valid_cycles: got %0d expected 1", vcyc - v0);
        end
        n_checks++;
        if (vrise - r0 !== 1) begin
            n_fail++; $display("FAIL basic_valid_pulses: got %0d expected 1", vrise - r0);
        end
        n_checks++;
        if (fcyc - f0 !== 0) begin
            n_fail++; $display("FAIL basic_ferr: got %0d expected 0", fcyc - f0);
        end
        v0 = vcyc;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(10);
        n_checks++;
        if (data_out !== 16'hFF00) begin
            n_fail++; $display("FAIL basic_data2: got %h expected %h", data_out, 16'hFF00);
        end
        n_checks++;
        if (vcyc - v0 !== 1) begin
            n_fail++; $display("FAIL basic_valid2: got %0d expected 1", vcyc - v0);
        end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = vcyc; f0 = fcyc;
        rx_in = 1'b0;
        repeat (3) @(negedge clk_in);
        idle(30);
        n_checks++;
        if (vcyc - v0 !== 0) begin
            n_fail++; $display("FAIL glitch_valid: got %0d expected 0", vcyc - v0);
        end
        n_checks++;
        if (fcyc - f0 !== 0) begin
            n_fail++; $display("FAIL glitch_ferr: got %0d expected 0", fcyc - f0);
        end
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(10);
        n_checks++;
        if (data_out !== 16'h3412) begin
            n_fail++; $display("FAIL glitch_recover: got %h expected %h", data_out, 16'h3412);
        end
        n_checks++;
        if (vcyc - v0 !== 1) begin
            n_fail++; $display("FAIL glitch_recover_valid: got %0d expected 1", vcyc - v0);
        end
    endtask

    task automatic test_frame_error();
        int v0, f0;
        v0 = vcyc; f0 = fcyc;
        send_byte(8'h11, 1'b0);
        idle(20);
        n_checks++;
        if (fcyc - f0 !== 1) begin
            n_fail++; $display("FAIL ferr_pulse: got %0d expected 1", fcyc - f0);
        end
        n_checks++;
        if (vcyc - v0 !== 0) begin
            n_fail++; $display("FAIL ferr_no_valid: got %0d expected 0", vcyc - v0);
        end
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(10);
        n_checks++;
        if (data_out !== 16'h3322) begin
            n_fail++; $display("FAIL ferr_next_word: got %h expected %h", data_out, 16'h3322);
        end
        n_checks++;
        if (vcyc - v0 !== 1) begin
            n_fail++; $display("FAIL ferr_next_valid: got %0d expected 1", vcyc - v0);
        end
        n_checks++;
        if (fcyc - f0 !== 1) begin
            n_fail++; $display("FAIL ferr_total: got %0d expected 1", fcyc - f0);
        end
    endtask

    task automatic test_mid_reset();
        int v0;
        send_byte(8'hFF, 1'b1);
        rx_in = 1'b0;
        repeat (25) @(negedge clk_in);
        skip_stab = 1'b1;
        rst_in = 1'b1;
        rx_in  = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        n_checks++;
        if (data_out !== 16'h0) begin
            n_fail++; $display("FAIL midrst_data: got %h expected %h", data_out, 16'h0);
        end
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++; $display("FAIL midrst_valid: got %b expected 0", valid_out);
        end
        n_checks++;
        if (frame_error_out !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ferr: got %b expected 0", frame_error_out);
        end
        idle(30);
        skip_stab = 1'b0;
        v0 = vcyc;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(10);
        n_checks++;
        if (data_out !== 16'h0201) begin
            n_fail++; $display("FAIL midrst_word: got %h expected %h", data_out, 16'h0201);
        end
        n_checks++;
        if (vcyc - v0 !== 1) begin
            n_fail++; $display("FAIL midrst_valid_count: got %0d expected 1", vcyc - v0);
        end
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = vcyc; f0 = fcyc;
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(10);
        n_checks++;
        if (vcyc - v0 !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 2", vcyc - v0);
        end
        n_checks++;
        if (vstamp[1] - vstamp[0] !== 20 * DIV) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", vstamp[1] - vstamp[0], 20 * DIV);
        end
        n_checks++;
        if (vdata[0] !== 16'hBEEF) begin
            n_fail++; $display("FAIL b2b_word0: got %h expected %h", vdata[0], 16'hBEEF);
        end
        n_checks++;
        if (vdata[1] !== 16'h1234) begin
            n_fail++; $display("FAIL b2b_word1: got %h expected %h", vdata[1], 16'h1234);
        end
        n_checks++;
        if (fcyc - f0 !== 0) begin
            n_fail++; $display("FAIL b2b_ferr: got %0d expected 0", fcyc - f0);
        end
    endtask

    task automatic test_timeout();
        int v0;
        logic [15:0] exp_word;
`ifdef RECEIVER_TIMEOUT_EN
        exp_word = 16'h0201;
`else
        exp_word = 16'h01AA;
`endif
        v0 = vcyc;
        send_byte(8'hAA, 1'b1);
        idle(250);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(10);
        n_checks++;
        if (data_out !== exp_word) begin
            n_fail++; $display("FAIL timeout_word: got %h expected %h", data_out, exp_word);
        end
        n_checks++;
        if (vcyc - v0 !== 1) begin
            n_fail++; $display("FAIL timeout_valid: got %0d expected 1", vcyc - v0);
        end
    endtask

    task automatic test_invariants();
        n_checks++;
        if (overlap !== 0) begin
            n_fail++; $display("FAIL valid_ferr_overlap: got %0d cycles expected 0", overlap);
        end
        n_checks++;
        if (stab_err !== 0) begin
            n_fail++; $display("FAIL data_stability: got %0d changes without valid expected 0", stab_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_mid_reset();
        test_back_to_back();
        test_timeout();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
